dmi_arbiter: RTL
================

DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent in WAIT before a synthesized failure response; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rN_req_valid (N=0,1), input, 1 bit: requester N presents a DMI request.
REQ-005 SHALL have port rN_req_ready, output, 1 bit: request from requester N accepted this cycle.
REQ-006 SHALL have ports rN_req_bits_addr, input, 7 bits; rN_req_bits_op, input, 2 bits; rN_req_bits_data, input, 32 bits: the request payload.
REQ-007 SHALL have port rN_resp_valid, output, 1 bit: response available to requester N.
REQ-008 SHALL have port rN_resp_ready, input, 1 bit: requester N takes the response.
REQ-009 SHALL have ports rN_resp_bits_resp, output, 2 bits, and rN_resp_bits_data, output, 32 bits: the response payload.
REQ-010 SHALL have ports debug_req_valid, output, 1; debug_req_ready, input, 1; debug_req_bits_addr, output, 7; debug_req_bits_op, output, 2; debug_req_bits_data, output, 32: the shared downstream DMI request channel.
REQ-011 SHALL have ports debug_resp_valid, input, 1; debug_resp_ready, output, 1; debug_resp_bits_resp, input, 2; debug_resp_bits_data, input, 32: the shared downstream DMI response channel.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port timeout_seen, output, 1 bit: sticky flag, set on any timeout.

Function
REQ-014 SHALL implement the FSM states IDLE, ISSUE, WAIT and DELIVER, with at most one transaction outstanding.
REQ-015 IDLE: if any rN_req_valid, SHALL assert rN_req_ready combinationally for the winner only, latch its addr/op/data and owner index, and go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester not in last_grant; with one valid, grant it; last_grant updates on acceptance.
REQ-017 ISSUE: debug_req_valid=1 with the latched payload, which is stable until the handshake; on debug_req_ready SHALL go to WAIT and clear the timeout counter.
REQ-018 WAIT: debug_resp_ready=1; on debug_resp_valid SHALL latch resp/data and go to DELIVER.
REQ-019 WAIT: the counter increments each cycle without debug_resp_valid; when it reaches TIMEOUT, SHALL latch resp=2'b10 and data=32'h0, set timeout_seen, and go to DELIVER.
REQ-020 debug_resp_valid arriving in the same cycle the counter reaches TIMEOUT: the real response SHALL win and timeout_seen SHALL NOT be set.
REQ-021 DELIVER: r<owner>_resp_valid=1 with the latched payload; the other requester's resp_valid SHALL be 0; on r<owner>_resp_ready SHALL go to IDLE.
REQ-022 A new request SHALL NOT be accepted in the DELIVER->IDLE cycle; minimum spacing is therefore 4 cycles per transaction (accept, issue, response, deliver).
REQ-023 Latency: accept at cycle t gives debug_req_valid at t+1; a response captured at cycle u gives rN_resp_valid at u+1.
REQ-024 rN_req_ready SHALL be 0 outside IDLE; debug_resp_ready SHALL be 0 outside WAIT.
REQ-025 The op value SHALL be passed unmodified, including op=0 (nop); the arbiter SHALL NOT decode it.
REQ-026 Once set, timeout_seen SHALL clear only on reset.

Reset
REQ-027 reset high at a rising edge SHALL set state=IDLE, last_grant=1 (requester 0 wins first), counter=0 and timeout_seen=0, and SHALL clear all latched payloads.
REQ-028 During and after reset, all valid/ready outputs and busy SHALL be 0 and all payload outputs 0.
REQ-029 Reset mid-transaction SHALL abandon it: no response is delivered to the owner, and any late downstream response is left unconsumed.

Verification
REQ-030 r0 only, addr=7'h10, op=2, data=32'hDEADBEEF; downstream ready at once, response 3 cycles later with resp=0, data=32'h12345678 -> debug_req fields match, r0_resp_valid carries resp=0 and data=32'h12345678, r1_resp_valid stays 0.
REQ-031 r0 and r1 valid continuously for 4 transactions -> grants r0, r1, r0, r1; each response is routed only to its owner.
REQ-032 TIMEOUT=8, downstream never answers -> r0_resp_valid rises 9 cycles after WAIT entry with resp=2, data=0; timeout_seen=1 and holds.
REQ-033 Response on the exact cycle the counter reaches TIMEOUT -> the real resp/data are delivered and timeout_seen stays 0.
REQ-034 r1_resp_ready held low 10 cycles in DELIVER -> payload stable, no new grants, busy=1; release leads to IDLE the next cycle.
REQ-035 reset asserted in WAIT -> next cycle all outputs 0 and busy=0; a subsequent r1 request is granted normally.

Source files
------------

// File: rtl/dmi_arbiter.sv
// ---------------------------------------------------------------------------
// dmi_arbiter
//   Two-requester round-robin arbiter in front of a single downstream DMI
//   port. At most one transaction is outstanding: it is accepted in IDLE,
//   presented downstream in ISSUE, its response is awaited in WAIT (with a
//   timeout that synthesizes a failure response), and it is returned to the
//   owning requester in DELIVER.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   rN_req_*   (N=0,1)     : upstream request channels (valid/ready + payload)
//   rN_resp_*  (N=0,1)     : upstream response channels (valid/ready + payload)
//   debug_req_*            : shared downstream request channel
//   debug_resp_*           : shared downstream response channel
//   busy                   : state is not IDLE
//   timeout_seen           : sticky, set by any timeout, cleared by reset only
// ---------------------------------------------------------------------------
module dmi_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic [6:0]  r0_req_bits_addr,
  input  logic [1:0]  r0_req_bits_op,
  input  logic [31:0] r0_req_bits_data,
  output logic        r0_resp_valid,
  input  logic        r0_resp_ready,
  output logic [1:0]  r0_resp_bits_resp,
  output logic [31:0] r0_resp_bits_data,

  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic [6:0]  r1_req_bits_addr,
  input  logic [1:0]  r1_req_bits_op,
  input  logic [31:0] r1_req_bits_data,
  output logic        r1_resp_valid,
  input  logic        r1_resp_ready,
  output logic [1:0]  r1_resp_bits_resp,
  output logic [31:0] r1_resp_bits_data,

  output logic        debug_req_valid,
  input  logic        debug_req_ready,
  output logic [6:0]  debug_req_bits_addr,
  output logic [1:0]  debug_req_bits_op,
  output logic [31:0] debug_req_bits_data,

  input  logic        debug_resp_valid,
  output logic        debug_resp_ready,
  input  logic [1:0]  debug_resp_bits_resp,
  input  logic [31:0] debug_resp_bits_data,

  output logic        busy,
  output logic        timeout_seen
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  localparam int CNT_W = 16;

  state_t             r_state;
  state_t             w_next;

  logic               r_last_grant;  // 1 -> requester 0 wins the next tie
  logic               r_owner;       // requester that owns the current txn
  logic [6:0]         r_addr;
  logic [1:0]         r_op;
  logic [31:0]        r_data;
  logic [1:0]         r_resp;
  logic [31:0]        r_rdata;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout_seen;

  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_any_gnt;
  logic               w_cnt_hit;
  logic               w_owner_rdy;

  // Round robin: on a tie the requester that did not win last time wins.
  assign w_gnt0    = r0_req_valid && (!r1_req_valid || r_last_grant);
  assign w_gnt1    = r1_req_valid && (!r0_req_valid || !r_last_grant);
  assign w_any_gnt = w_gnt0 || w_gnt1;

  assign w_cnt_hit   = (r_cnt == CNT_W'(TIMEOUT));
  assign w_owner_rdy = r_owner ? r1_resp_ready : r0_resp_ready;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any_gnt)                      w_next = S_ISSUE;
      S_ISSUE:   if (debug_req_ready)                w_next = S_WAIT;
      // A real response and the timeout may coincide; either way DELIVER.
      S_WAIT:    if (debug_resp_valid || w_cnt_hit)  w_next = S_DELIVER;
      S_DELIVER: if (w_owner_rdy)                    w_next = S_IDLE;
      default:                                       w_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. Everything is forced low while reset is high so that the
  // reset cycle itself shows a quiet interface, not just the cycle after.
  // -------------------------------------------------------------------------
  always_comb begin
    r0_req_ready        = 1'b0;
    r1_req_ready        = 1'b0;
    r0_resp_valid       = 1'b0;
    r1_resp_valid       = 1'b0;
    r0_resp_bits_resp   = '0;
    r0_resp_bits_data   = '0;
    r1_resp_bits_resp   = '0;
    r1_resp_bits_data   = '0;
    debug_req_valid     = 1'b0;
    debug_req_bits_addr = '0;
    debug_req_bits_op   = '0;
    debug_req_bits_data = '0;
    debug_resp_ready    = 1'b0;
    busy                = 1'b0;
    timeout_seen        = 1'b0;
    if (!reset) begin
      busy                = (r_state != S_IDLE);
      timeout_seen        = r_timeout_seen;
      debug_req_bits_addr = r_addr;
      debug_req_bits_op   = r_op;
      debug_req_bits_data = r_data;
      // Response payload is only presented to the owner.
      if (!r_owner) begin
        r0_resp_bits_resp = r_resp;
        r0_resp_bits_data = r_rdata;
      end else begin
        r1_resp_bits_resp = r_resp;
        r1_resp_bits_data = r_rdata;
      end
      case (r_state)
        S_IDLE: begin
          r0_req_ready = w_gnt0;
          r1_req_ready = w_gnt1;
        end
        S_ISSUE:   debug_req_valid  = 1'b1;
        S_WAIT:    debug_resp_ready = 1'b1;
        S_DELIVER: begin
          r0_resp_valid = !r_owner;
          r1_resp_valid = r_owner;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: request latch, grant history, timeout counter, response latch
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant   <= 1'b1;
      r_owner        <= 1'b0;
      r_addr         <= '0;
      r_op           <= '0;
      r_data         <= '0;
      r_resp         <= '0;
      r_rdata        <= '0;
      r_cnt          <= '0;
      r_timeout_seen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_gnt) begin
            r_owner      <= w_gnt1;
            r_last_grant <= w_gnt1;
            // op is forwarded untouched; the arbiter never interprets it.
            r_addr       <= w_gnt1 ? r1_req_bits_addr : r0_req_bits_addr;
            r_op         <= w_gnt1 ? r1_req_bits_op   : r0_req_bits_op;
            r_data       <= w_gnt1 ? r1_req_bits_data : r0_req_bits_data;
          end
        end
        S_ISSUE: begin
          if (debug_req_ready) r_cnt <= '0;
        end
        S_WAIT: begin
          if (debug_resp_valid) begin
            r_resp  <= debug_resp_bits_resp;
            r_rdata <= debug_resp_bits_data;
          end else if (w_cnt_hit) begin
            r_resp         <= 2'b10;
            r_rdata        <= 32'h0;
            r_timeout_seen <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
